// File: rtl/priority_arbiter.sv
// Registered N-input arbiter: fixed (highest index wins) or round-robin selection,
// with each grant held on a valid/ready handshake until the consumer accepts it.
module priority_arbiter #(
    parameter int N  = 4,
    parameter int RR = 0,
    localparam int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         grant_ready,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         any_req,
    output logic         dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [N-1:0]   onehot_q, onehot_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic [W-1:0]   hi_idx;
    logic [W-1:0]   lo_idx;
    logic           lo_found;
    logic [W-1:0]   win_idx;

    // Round-robin order ptr, ptr-1, ..., 0, N-1, ..., ptr+1 reduces to: the highest
    // request at or below ptr, else the highest request overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                hi_idx = W'(i);
                if (W'(i) <= ptr_q) begin
                    lo_idx   = W'(i);
                    lo_found = 1'b1;
                end
            end
        end
        if (RR != 0 && lo_found) begin
            win_idx = lo_idx;
        end else begin
            win_idx = hi_idx;
        end
    end

    // Handshake: a grant is transferred on any edge where grant_valid && grant_ready;
    // grant_valid never drops and grant_idx/grant_onehot never change until then.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d    = win_idx;
                    onehot_d = N'(1) << win_idx;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (grant_ready) begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    state_d  = IDLE;
                    if (RR != 0) begin
                        ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= W'(N - 1);
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_valid  = valid_q;
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign any_req      = |req;
    assign dbg_state    = (state_q == HOLD);

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: fixed N=4, round-robin N=4 and round-robin N=5
// instances, driven one after another from a single stimulus sequence.
module tb_priority_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fixed priority, N=4
    logic       f_rst, f_ready, f_valid, f_any, f_dbg;
    logic [3:0] f_req, f_onehot;
    logic [1:0] f_idx;
    // round-robin, N=4
    logic       r_rst, r_ready, r_valid, r_any, r_dbg;
    logic [3:0] r_req, r_onehot;
    logic [1:0] r_idx;
    // round-robin, N=5
    logic       q_rst, q_ready, q_valid, q_any, q_dbg;
    logic [4:0] q_req, q_onehot;
    logic [2:0] q_idx;

    priority_arbiter #(.N(4), .RR(0)) u_fix (
        .clk(clk), .rst(f_rst), .req(f_req), .grant_ready(f_ready),
        .grant_valid(f_valid), .grant_idx(f_idx), .grant_onehot(f_onehot),
        .any_req(f_any), .dbg_state(f_dbg)
    );

    priority_arbiter #(.N(4), .RR(1)) u_rr4 (
        .clk(clk), .rst(r_rst), .req(r_req), .grant_ready(r_ready),
        .grant_valid(r_valid), .grant_idx(r_idx), .grant_onehot(r_onehot),
        .any_req(r_any), .dbg_state(r_dbg)
    );

    priority_arbiter #(.N(5), .RR(1)) u_rr5 (
        .clk(clk), .rst(q_rst), .req(q_req), .grant_ready(q_ready),
        .grant_valid(q_valid), .grant_idx(q_idx), .grant_onehot(q_onehot),
        .any_req(q_any), .dbg_state(q_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rr4_seq[5];
        int rr5_seq[4];
        rr4_seq = '{3, 2, 1, 0, 3};
        rr5_seq = '{2, 0, 2, 0};

        f_rst = 1'b1; f_req = 4'b1111; f_ready = 1'b0;
        r_rst = 1'b1; r_req = 4'b0000; r_ready = 1'b0;
        q_rst = 1'b1; q_req = 5'b00000; q_ready = 1'b0;

        // reset with all requests active
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_valid", f_valid, 0);
            check("rst_onehot", f_onehot, 4'b0000);
            check("rst_idx", f_idx, 0);
            check("rst_any_req", f_any, 1);
            check("rst_state", f_dbg, 0);
        end
        f_rst = 1'b0; f_req = 4'b0000;
        r_rst = 1'b0; q_rst = 1'b0;
        check("any_req_zero", f_any, 0);
        tick();
        check("idle_valid", f_valid, 0);
        tick();
        check("idle_valid2", f_valid, 0);

        // fixed priority 0110 -> 2, accept, bubble, 2 again
        f_req = 4'b0110; f_ready = 1'b1;
        tick();
        check("fix_valid", f_valid, 1);
        check("fix_idx", f_idx, 2);
        check("fix_onehot", f_onehot, 4'b0100);
        check("fix_state_hold", f_dbg, 1);
        tick();
        check("fix_acc_valid", f_valid, 0);
        check("fix_acc_onehot", f_onehot, 4'b0000);
        check("fix_idx_kept", f_idx, 2);
        tick();
        check("fix_regrant_valid", f_valid, 1);
        check("fix_regrant_idx", f_idx, 2);
        tick();
        check("fix_acc2_valid", f_valid, 0);

        // backpressure: grant to 0 held while req moves to 1000
        f_req = 4'b0001; f_ready = 1'b0;
        tick();
        check("bp_valid", f_valid, 1);
        check("bp_idx", f_idx, 0);
        f_req = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", f_valid, 1);
            check("bp_hold_idx", f_idx, 0);
            check("bp_hold_onehot", f_onehot, 4'b0001);
        end
        f_ready = 1'b1;
        tick();
        check("bp_acc_valid", f_valid, 0);
        tick();
        check("bp_next_valid", f_valid, 1);
        check("bp_next_idx", f_idx, 3);
        check("bp_next_onehot", f_onehot, 4'b1000);
        f_req = 4'b0000;
        tick();
        check("bp_next_acc", f_valid, 0);
        tick();
        check("fix_idle_after", f_valid, 0);

        // round-robin rotation N=4
        r_req = 4'b1111; r_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr4_valid", r_valid, 1);
            check("rr4_idx", r_idx, rr4_seq[g]);
            check("rr4_onehot", r_onehot, 4'b0001 << rr4_seq[g]);
            tick();
            check("rr4_acc", r_valid, 0);
        end
        r_req = 4'b0000;

        // round-robin skip N=5
        q_req = 5'b00101; q_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("rr5_valid", q_valid, 1);
            check("rr5_idx", q_idx, rr5_seq[g]);
            check("rr5_onehot", q_onehot, 5'b00001 << rr5_seq[g]);
            tick();
            check("rr5_acc", q_valid, 0);
        end
        // ptr now N-1 = 4: request 4 and 0 -> 4 first, then 0
        q_req = 5'b10001;
        tick();
        check("rr5_wrap_idx", q_idx, 4);
        tick();
        tick();
        check("rr5_after4_idx", q_idx, 0);
        q_req = 5'b00000;
        tick();
        check("rr5_end_valid", q_valid, 0);

        // mid-HOLD reset on RR N=4 (ptr is 2 here, so 3 is found by wrapping)
        r_req = 4'b1000; r_ready = 1'b0;
        tick();
        check("mh_valid", r_valid, 1);
        check("mh_idx", r_idx, 3);
        r_rst = 1'b1; r_ready = 1'b1;
        tick();
        check("mh_rst_valid", r_valid, 0);
        check("mh_rst_onehot", r_onehot, 4'b0000);
        check("mh_rst_idx", r_idx, 0);
        r_rst = 1'b0; r_req = 4'b1111;
        tick();
        check("mh_first_valid", r_valid, 1);
        check("mh_first_idx", r_idx, 3);
        tick();
        tick();
        check("mh_second_idx", r_idx, 2);
        r_req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Parametrised, registered N-input priority encoder/arbiter with a valid/ready output handshake. It supports fixed-priority mode (highest index wins) and round-robin mode. Each grant is held stable until the consumer accepts it. The block sits between a bank of request lines and a single shared consumer (bus master, service unit). It is the sequential, generalised successor to the team's 4-input combinational priority encoder.

## Interface
Parameters:
- N, default 4: number of request inputs, N >= 2.
- RR, default 0: 0 selects fixed priority, 1 selects round-robin.
- W, derived as max(1, clog2(N)): grant index width. Local, not overridable.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- req  in  N  request vector; bit i is set when requester i wants service.
- grant_ready  in  1  consumer accepts the presented grant.
- grant_valid  out  1  a grant is presented on grant_idx/grant_onehot.
- grant_idx  out  W  binary index of the granted requester.
- grant_onehot  out  N  one-hot form of grant_idx; all zeros when grant_valid=0.
- any_req  out  1  combinational OR of req (the "v" output of the older encoder).

## Operation
- Two states, IDLE and HOLD.
- IDLE:
  - If req == 0, stay in IDLE; outputs unchanged (grant_valid=0).
  - If req != 0, select a winner, register grant_idx/grant_onehot, set grant_valid=1, go to HOLD.
- Fixed mode (RR=0): winner is the highest set index of req (N-1 highest priority, 0 lowest).
- Round-robin mode (RR=1):
  - Search starts at pointer ptr (W bits) and goes downward: ptr, ptr-1, …, 0, N-1, …, ptr+1. The first set bit wins.
  - ptr resets to N-1, so the first arbitration after reset matches fixed mode.
- HOLD:
  - grant_idx, grant_onehot and grant_valid stay constant.
  - req is not sampled. A requester that drops req keeps its grant until the grant is accepted.
  - On grant_valid && grant_ready: grant_valid=0 and grant_onehot=0 at the next edge; go to IDLE.
  - RR only, on accept: ptr ← grant_idx−1 mod N. A grant to index 0 wraps ptr to N-1.
  - While grant_ready=0: remain in HOLD indefinitely; ptr unchanged.
- Fixed mode: ptr is unused and may be optimised away.
- grant_idx keeps its last value after accept. Only grant_onehot clears.
- N not a power of two: indices ≥ N never granted; ptr wrap uses N, not 2^W.

## Timing
- Reset values:
  - grant_valid=0, grant_idx=0, grant_onehot=0, ptr=N-1, state IDLE.
  - any_req follows req combinationally, even during reset.
- Reset during HOLD: grant dropped at that edge, ptr returns to N-1, and no accept is recorded even if grant_ready=1 in the same cycle.
- Latency:
  - req sampled in IDLE at edge k gives grant_valid=1 after edge k.
  - Accept at edge m drops grant_valid after edge m.
  - The earliest next grant is after edge m+1.
- Throughput: at most one grant per 2 cycles, with a mandatory one-cycle IDLE bubble between grants.
- grant_ready is ignored while grant_valid=0.
- All outputs except any_req are registered; there are no combinational paths from req or grant_ready to grant_*.

## Test plan
- Reset/idle: N=4, assert rst 2 cycles with req=4'b1111 -> grant_valid=0, grant_onehot=0, grant_idx=0, any_req=1. Deassert rst, req=0 -> grant_valid stays 0.
- Fixed priority: N=4, RR=0, req=4'b0110, grant_ready=1 -> one cycle later grant_idx=2, grant_onehot=4'b0100. Accepted next edge, then a bubble, then grant_idx=2 again.
- Backpressure: req=4'b0001, grant_ready=0 for 5 cycles while req changes to 4'b1000 -> grant_idx=0 held all 5 cycles. After grant_ready=1 and the bubble, next grant_idx=3.
- Round-robin rotation: N=4, RR=1, req=4'b1111 held, grant_ready=1 -> grant sequence 3,2,1,0,3 with ptr wrapping 0→3.
- Round-robin skip: N=5, RR=1, req=5'b00101 -> grants 2,0,2,0. Confirms non-power-of-two wrap: ptr after grant 0 is 4, not 7.
- Mid-HOLD reset: RR=1, grant to 3 presented, assert rst together with grant_ready=1 -> grant_valid=0 next edge. After release with req=4'b1111, first grant_idx=3 (ptr reset to N-1).
